ex_mem_stage: RTL and testbench

//  EX/MEM pipeline register of the 16-bit pipelined CPU. Sits directly downstream of the ALU.

---
 rtl/ex_mem_stage.sv | 169 ++++++++++++++++
 tb/tb_ex_mem_stage.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_stage.sv
`default_nettype none
// ============================================================================
//  Module   : ex_mem_stage
//  Purpose  : EX/MEM pipeline register of the 16-bit CPU with the WWD output
//             port, stall/flush handling and the HLT drain-then-halt sequence.
//             Optional macro FORWARD_PORT_EN adds the EX->EX bypass outputs.
//  Revision : 1.0  initial release
// ============================================================================
module ex_mem_stage #(
    parameter int WORD_SIZE  = 16,
    parameter int REG_ADDR_W = 2,
    parameter int HALT_DRAIN = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ex_valid,
    input  logic [WORD_SIZE-1:0]  ex_alu_c,
    input  logic [WORD_SIZE-1:0]  ex_b,
    input  logic [REG_ADDR_W-1:0] ex_dest,
    input  logic                  ex_reg_write,
    input  logic                  ex_mem_read,
    input  logic                  ex_mem_write,
    input  logic                  ex_out_en,
    input  logic [WORD_SIZE-1:0]  ex_out_val,
    input  logic                  ex_is_hlt,
    input  logic                  stall,
    input  logic                  flush,
    output logic                  ex_ready,
    output logic                  mem_valid,
    output logic [WORD_SIZE-1:0]  mem_alu_c,
    output logic [WORD_SIZE-1:0]  mem_wdata,
    output logic [REG_ADDR_W-1:0] mem_dest,
    output logic                  mem_reg_write,
    output logic                  mem_mem_read,
    output logic                  mem_mem_write,
    output logic [WORD_SIZE-1:0]  output_port,
    output logic                  out_strobe,
`ifdef FORWARD_PORT_EN
    output logic                  fwd_valid,
    output logic [REG_ADDR_W-1:0] fwd_dest,
    output logic [WORD_SIZE-1:0]  fwd_data,
`endif
    output logic                  is_halted
);

    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_DRAIN  = 2'd1;
    localparam logic [1:0] ST_HALTED = 2'd2;
    localparam logic [3:0] c_DRAIN_INIT = 4'(HALT_DRAIN);

    logic [1:0]            state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  valid_q, valid_d;
    logic [WORD_SIZE-1:0]  alu_c_q, alu_c_d;
    logic [WORD_SIZE-1:0]  wdata_q, wdata_d;
    logic [REG_ADDR_W-1:0] dest_q, dest_d;
    logic                  reg_write_q, reg_write_d;
    logic                  mem_read_q, mem_read_d;
    logic                  mem_write_q, mem_write_d;
    logic [WORD_SIZE-1:0]  port_q, port_d;
    logic                  strobe_q, strobe_d;
    logic                  w_cap;

    assign w_cap = ex_valid & ~flush & ~stall & (state_q == ST_RUN);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        valid_d     = valid_q;
        alu_c_d     = alu_c_q;
        wdata_d     = wdata_q;
        dest_d      = dest_q;
        reg_write_d = reg_write_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        port_d      = port_q;
        strobe_d    = 1'b0;

        // A stalled cycle freezes everything except the strobe, which is a pulse.
        if (!stall) begin
            valid_d     = 1'b0;
            alu_c_d     = '0;
            wdata_d     = '0;
            dest_d      = '0;
            reg_write_d = 1'b0;
            mem_read_d  = 1'b0;
            mem_write_d = 1'b0;
            case (state_q)
                ST_RUN: begin
                    if (w_cap) begin
                        if (ex_is_hlt) begin
                            state_d = ST_DRAIN;
                            cnt_d   = c_DRAIN_INIT;
                        end else begin
                            valid_d     = 1'b1;
                            alu_c_d     = ex_alu_c;
                            wdata_d     = ex_b;
                            dest_d      = ex_dest;
                            reg_write_d = ex_reg_write;
                            mem_read_d  = ex_mem_read;
                            mem_write_d = ex_mem_write;
                            if (ex_out_en) begin
                                port_d   = ex_out_val;
                                strobe_d = 1'b1;
                            end
                        end
                    end
                end
                ST_DRAIN: begin
                    if (cnt_q == 4'd1) begin
                        state_d = ST_HALTED;
                        cnt_d   = 4'd0;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_RUN;
            cnt_q       <= 4'd0;
            valid_q     <= 1'b0;
            alu_c_q     <= '0;
            wdata_q     <= '0;
            dest_q      <= '0;
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            port_q      <= '0;
            strobe_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            valid_q     <= valid_d;
            alu_c_q     <= alu_c_d;
            wdata_q     <= wdata_d;
            dest_q      <= dest_d;
            reg_write_q <= reg_write_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            port_q      <= port_d;
            strobe_q    <= strobe_d;
        end
    end

    assign ex_ready      = ~stall & (state_q == ST_RUN);
    assign mem_valid     = valid_q;
    assign mem_alu_c     = alu_c_q;
    assign mem_wdata     = wdata_q;
    assign mem_dest      = dest_q;
    assign mem_reg_write = reg_write_q & valid_q;
    assign mem_mem_read  = mem_read_q & valid_q;
    assign mem_mem_write = mem_write_q & valid_q;
    assign output_port   = port_q;
    assign out_strobe    = strobe_q;
    assign is_halted     = (state_q == ST_HALTED);

`ifdef FORWARD_PORT_EN
    assign fwd_valid = valid_q & reg_write_q & ~mem_read_q;
    assign fwd_dest  = dest_q;
    assign fwd_data  = alu_c_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ex_mem_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ex_mem_stage
//  Purpose  : Directed + randomized self-checking bench for ex_mem_stage
//             against a cycle-level behavioural model (FORWARD_PORT_EN aware).
//  Revision : 1.0  initial release
// ============================================================================
module tb_ex_mem_stage;

    localparam int W  = 16;
    localparam int RA = 2;
    localparam int HD = 2;

    logic          clk = 1'b0;
    logic          reset, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write;
    logic          ex_out_en, ex_is_hlt, stall, flush;
    logic [W-1:0]  ex_alu_c, ex_b, ex_out_val;
    logic [RA-1:0] ex_dest;
    logic          ex_ready, mem_valid, mem_reg_write, mem_mem_read, mem_mem_write;
    logic          out_strobe, is_halted;
    logic [W-1:0]  mem_alu_c, mem_wdata, output_port;
    logic [RA-1:0] mem_dest;
`ifdef FORWARD_PORT_EN
    logic          fwd_valid;
    logic [RA-1:0] fwd_dest;
    logic [W-1:0]  fwd_data;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model of what the stage should show after each edge.
    logic          m_valid, m_rw, m_mr, m_mw, m_strobe, m_halted;
    logic [W-1:0]  m_alu, m_wdata, m_port;
    logic [RA-1:0] m_dest;
    int            m_drain_left;

    always #5 clk = ~clk;

    ex_mem_stage #(.WORD_SIZE(W), .REG_ADDR_W(RA), .HALT_DRAIN(HD)) dut (
        .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_alu_c(ex_alu_c),
        .ex_b(ex_b), .ex_dest(ex_dest), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_out_en(ex_out_en), .ex_out_val(ex_out_val), .ex_is_hlt(ex_is_hlt),
        .stall(stall), .flush(flush), .ex_ready(ex_ready), .mem_valid(mem_valid),
        .mem_alu_c(mem_alu_c), .mem_wdata(mem_wdata), .mem_dest(mem_dest),
        .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read),
        .mem_mem_write(mem_mem_write), .output_port(output_port),
        .out_strobe(out_strobe),
`ifdef FORWARD_PORT_EN
        .fwd_valid(fwd_valid), .fwd_dest(fwd_dest), .fwd_data(fwd_data),
`endif
        .is_halted(is_halted)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_idle();
        reset = 0; ex_valid = 0; ex_alu_c = '0; ex_b = '0; ex_dest = '0;
        ex_reg_write = 0; ex_mem_read = 0; ex_mem_write = 0; ex_out_en = 0;
        ex_out_val = '0; ex_is_hlt = 0; stall = 0; flush = 0;
    endtask

    task automatic model_bubble();
        m_valid = 0; m_alu = '0; m_wdata = '0; m_dest = '0;
        m_rw = 0; m_mr = 0; m_mw = 0;
    endtask

    // One clock: check ex_ready, advance the model, clock the DUT, compare.
    task automatic tick();
        bit accepting;
        #1;
        accepting = !m_halted && (m_drain_left == 0);
        if (!reset) check_eq("ex_ready", 32'(ex_ready), 32'(!stall && accepting));
        if (reset) begin
            model_bubble();
            m_port = '0; m_strobe = 0; m_halted = 0; m_drain_left = 0;
        end else if (stall) begin
            m_strobe = 0;
        end else begin
            m_strobe = 0;
            model_bubble();
            if (accepting && ex_valid && !flush) begin
                if (ex_is_hlt) begin
                    m_drain_left = HD;
                end else begin
                    m_valid = 1; m_alu = ex_alu_c; m_wdata = ex_b; m_dest = ex_dest;
                    m_rw = ex_reg_write; m_mr = ex_mem_read; m_mw = ex_mem_write;
                    if (ex_out_en) begin
                        m_port = ex_out_val;
                        m_strobe = 1;
                    end
                end
            end else if (m_drain_left > 0) begin
                m_drain_left--;
                if (m_drain_left == 0) m_halted = 1;
            end
        end
        @(posedge clk);
        #1;
        check_eq("mem_valid", 32'(mem_valid), 32'(m_valid));
        check_eq("mem_alu_c", 32'(mem_alu_c), 32'(m_alu));
        check_eq("mem_wdata", 32'(mem_wdata), 32'(m_wdata));
        check_eq("mem_dest", 32'(mem_dest), 32'(m_dest));
        check_eq("mem_reg_write", 32'(mem_reg_write), 32'(m_rw));
        check_eq("mem_mem_read", 32'(mem_mem_read), 32'(m_mr));
        check_eq("mem_mem_write", 32'(mem_mem_write), 32'(m_mw));
        check_eq("output_port", 32'(output_port), 32'(m_port));
        check_eq("out_strobe", 32'(out_strobe), 32'(m_strobe));
        check_eq("is_halted", 32'(is_halted), 32'(m_halted));
`ifdef FORWARD_PORT_EN
        check_eq("fwd_valid", 32'(fwd_valid), 32'(m_valid && m_rw && !m_mr));
        check_eq("fwd_dest", 32'(fwd_dest), 32'(m_dest));
        check_eq("fwd_data", 32'(fwd_data), 32'(m_alu));
`endif
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int op;
        model_bubble();
        m_port = '0; m_strobe = 0; m_halted = 0; m_drain_left = 0;
        set_idle();
        @(negedge clk);

        // Reset with a live instruction on the inputs.
        reset = 1; ex_valid = 1; ex_alu_c = 16'hFFFF;
        tick(); tick();
        set_idle();

        // Simple ALU capture then an idle cycle.
        ex_valid = 1; ex_alu_c = 16'h0005; ex_dest = 2; ex_reg_write = 1;
        tick();
        check_eq("add_result", 32'(mem_alu_c), 32'h0005);
        set_idle();
        tick();

        // Stall holds the captured value.
        ex_valid = 1; ex_alu_c = 16'h0005; ex_dest = 2; ex_reg_write = 1;
        tick();
        ex_alu_c = 16'h1234; stall = 1;
        repeat (3) tick();
        check_eq("stall_hold", 32'(mem_alu_c), 32'h0005);
        stall = 0;
        tick();
        check_eq("after_stall", 32'(mem_alu_c), 32'h1234);
        set_idle();

        // WWD, then a flushed WWD.
        ex_valid = 1; ex_out_en = 1; ex_out_val = 16'hBEEF;
        tick();
        check_eq("wwd_port", 32'(output_port), 32'hBEEF);
        ex_out_val = 16'h1111; flush = 1;
        tick();
        check_eq("flushed_wwd", 32'(output_port), 32'hBEEF);
        set_idle();
        tick();

        // HLT with one stall inside the drain window, then hold in HALTED.
        ex_valid = 1; ex_is_hlt = 1; ex_out_en = 1; ex_out_val = 16'h7777;
        tick();
        set_idle();
        tick();
        stall = 1; tick(); stall = 0;
        tick();
        check_eq("halted_rise", 32'(is_halted), 32'h1);
        ex_valid = 1; ex_alu_c = 16'h4242; ex_reg_write = 1;
        repeat (3) tick();
        set_idle();
        reset = 1; tick(); reset = 0;

        // Reset while draining returns to RUN.
        ex_valid = 1; ex_is_hlt = 1;
        tick();
        set_idle();
        reset = 1; tick(); reset = 0;
        tick();
        check_eq("reset_in_drain", 32'(is_halted), 32'h0);

`ifdef FORWARD_PORT_EN
        ex_valid = 1; ex_dest = 1; ex_reg_write = 1; ex_mem_read = 1;
        tick();
        check_eq("fwd_lwd", 32'(fwd_valid), 32'h0);
        set_idle();
        ex_valid = 1; ex_dest = 3; ex_reg_write = 1; ex_alu_c = 16'h00A0;
        tick();
        check_eq("fwd_add", 32'({fwd_valid, fwd_dest, fwd_data}), 32'({1'b1, 2'd3, 16'h00A0}));
        set_idle();
`endif

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            set_idle();
            reset      = ($urandom_range(0, 59) == 0);
            stall      = ($urandom_range(0, 4) == 0);
            flush      = ($urandom_range(0, 7) == 0);
            ex_valid   = ($urandom_range(0, 3) != 0);
            ex_alu_c   = 16'($urandom);
            ex_b       = 16'($urandom);
            ex_out_val = 16'($urandom);
            ex_dest    = 2'($urandom_range(0, 3));
            op = $urandom_range(0, 39);
            if (op == 0)       ex_is_hlt = 1;
            else if (op == 1) begin ex_is_hlt = 1; ex_out_en = 1; end
            else if (op < 12)  ex_out_en = 1;
            else if (op < 20)  begin ex_reg_write = 1; ex_mem_read = 1; end
            else if (op < 26)  ex_mem_write = 1;
            else               ex_reg_write = 1;
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
